// File: rtl/main_bus_master.sv
// Initiator for the multiplexed address/data main bus.
// Ports:
//   clk, resetH         : clock, async active-high reset
//   req_valid/req_ready : request handshake (rw, addr, wdata)
//   rsp_valid/rsp_rdata : one-cycle completion, read words
//   AddrValid, rw       : address-phase strobe, direction
//   AddrData_o/_oe/_i   : bus drive, bus enable, bus sample
module main_bus_master #(
  parameter int DW    = 16,
  parameter int BURST = 4
) (
  input  logic                clk,
  input  logic                resetH,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_rw,
  input  logic [DW-1:0]       req_addr,
  input  logic [DW*BURST-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [DW*BURST-1:0] rsp_rdata,
  output logic                AddrValid,
  output logic                rw,
  output logic [DW-1:0]       AddrData_o,
  output logic                AddrData_oe,
  input  logic [DW-1:0]       AddrData_i
);

  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BW-1:0] LAST = BW'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [BW-1:0]       nxt;
  logic [DW*BURST-1:0] wdata_q, wdata_d;
  logic [DW*BURST-1:0] rbuf_q, rbuf_d;
  logic [DW*BURST-1:0] rdata_q, rdata_d;
  logic                rdy_q, rdy_d;
  logic                rsp_q, rsp_d;
  logic                av_q, av_d;
  logic                rw_q, rw_d;
  logic [DW-1:0]       ado_q, ado_d;
  logic                oe_q, oe_d;

  // Every output is a flop: the next-cycle bus value is
  // computed here from the state being entered.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    rsp_d   = 1'b0;
    av_d    = 1'b0;
    rw_d    = rw_q;
    ado_d   = '0;
    oe_d    = 1'b0;
    nxt     = beat_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (req_valid && rdy_q) begin
          state_d = ADDR;
          beat_d  = '0;
          wdata_d = req_wdata;
          rw_d    = req_rw;
          av_d    = 1'b1;
          oe_d    = 1'b1;
          ado_d   = req_addr;
        end
      end
      ADDR: begin
        state_d = DATA;
        beat_d  = '0;
        oe_d    = ~rw_q;
        ado_d   = rw_q ? '0 : wdata_q[0 +: DW];
      end
      DATA: begin
        if (rw_q) begin
          rbuf_d[DW*int'(beat_q) +: DW] = AddrData_i;
        end
        if (beat_q == LAST) begin
          state_d = IDLE;
          rsp_d   = 1'b1;
          // Read data is published only on completion so
          // rsp_rdata keeps the previous read until then.
          if (rw_q) begin
            rdata_d = rbuf_d;
          end
        end else begin
          beat_d = nxt;
          oe_d   = ~rw_q;
          ado_d  = rw_q ? '0 : wdata_q[DW*int'(nxt) +: DW];
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge resetH) begin
    if (resetH) begin
      state_q <= IDLE;
      beat_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b1;
      rsp_q   <= 1'b0;
      av_q    <= 1'b0;
      rw_q    <= 1'b0;
      ado_q   <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      rsp_q   <= rsp_d;
      av_q    <= av_d;
      rw_q    <= rw_d;
      ado_q   <= ado_d;
      oe_q    <= oe_d;
    end
  end

  assign req_ready   = rdy_q;
  assign rsp_valid   = rsp_q;
  assign rsp_rdata   = rdata_q;
  assign AddrValid   = av_q;
  assign rw          = rw_q;
  assign AddrData_o  = ado_q;
  assign AddrData_oe = oe_q;

endmodule

// File: tb/tb_main_bus_master.sv
// Bench for main_bus_master: BURST=4 instance against a
// memory-slave model, plus a BURST=1 instance.
module tb_main_bus_master;

  localparam int DW = 16;
  localparam int B  = 4;

  logic clk = 1'b0;
  logic resetH;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_rw;
  logic [15:0]   req_addr;
  logic [63:0]   req_wdata;
  logic          rsp_valid;
  logic [63:0]   rsp_rdata;
  logic          AddrValid, rw, AddrData_oe;
  logic [15:0]   AddrData_o, AddrData_i;

  logic          req_valid1, req_ready1, req_rw1;
  logic [15:0]   req_addr1, req_wdata1;
  logic          rsp_valid1;
  logic [15:0]   rsp_rdata1;
  logic          AddrValid1, rw1, AddrData_oe1;
  logic [15:0]   AddrData_o1, AddrData_i1;

  main_bus_master #(.DW(DW), .BURST(B)) u0 (
    .clk(clk), .resetH(resetH),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .AddrValid(AddrValid), .rw(rw),
    .AddrData_o(AddrData_o), .AddrData_oe(AddrData_oe),
    .AddrData_i(AddrData_i)
  );

  main_bus_master #(.DW(DW), .BURST(1)) u1 (
    .clk(clk), .resetH(resetH),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_rw(req_rw1), .req_addr(req_addr1),
    .req_wdata(req_wdata1),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
    .AddrValid(AddrValid1), .rw(rw1),
    .AddrData_o(AddrData_o1), .AddrData_oe(AddrData_oe1),
    .AddrData_i(AddrData_i1)
  );

  function automatic logic [15:0] init_val(logic [7:0] i);
    return {i, ~i} ^ 16'h5A5A;
  endfunction

  // Slave: latches base on AddrValid, then B beats with
  // its own address increment.
  logic [15:0] sptr;
  int          sbeat;
  logic        srw;
  logic [15:0] mem [256];
  bit          written [256];

  always @(posedge clk or posedge resetH) begin
    if (resetH) begin
      sbeat <= 0;
      sptr  <= '0;
      srw   <= 1'b0;
    end else if (AddrValid) begin
      sptr  <= AddrData_o;
      sbeat <= B;
      srw   <= rw;
    end else if (sbeat > 0) begin
      if (!srw) begin
        mem[sptr[7:0]]     <= AddrData_o;
        written[sptr[7:0]] <= 1'b1;
      end
      sptr  <= sptr + 16'd1;
      sbeat <= sbeat - 1;
    end
  end

  always_comb begin
    AddrData_i = 16'h0;
    if (sbeat > 0 && srw) begin
      AddrData_i = written[sptr[7:0]] ? mem[sptr[7:0]]
                                      : init_val(sptr[7:0]);
    end
  end

  // Reference model state.
  logic [15:0] ref_mem [256];
  logic [63:0] last_rd;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_rsp", rsp_valid, 0);
      chk("idle_av", AddrValid, 0);
      chk("idle_rdy", req_ready, 1);
    end
  endtask

  task automatic txn(input logic trw,
                     input logic [15:0] a,
                     input logic [63:0] wd,
                     input int pulse,
                     input int rstb,
                     output logic [63:0] rd);
    logic [63:0] xrd;
    logic [15:0] ai;
    logic [15:0] w;
    xrd = '0;
    chk("rdy_pre", req_ready, 1);
    req_valid = 1'b1;
    req_rw    = trw;
    req_addr  = a;
    req_wdata = wd;
    step();
    req_valid = 1'b0;
    req_rw    = 1'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = {$urandom, $urandom};
    chk("adr_av", AddrValid, 1);
    chk("adr_oe", AddrData_oe, 1);
    chk("adr_val", AddrData_o, a);
    chk("adr_rw", rw, trw);
    chk("adr_rdy", req_ready, 0);
    chk("adr_rsp", rsp_valid, 0);
    for (int k = 0; k < B; k++) begin
      step();
      w = trw ? 16'h0 : wd[k*DW +: DW];
      ai = a + 16'(k);
      if (trw) xrd[k*DW +: DW] = ref_mem[ai[7:0]];
      chk("beat_av", AddrValid, 0);
      chk("beat_oe", AddrData_oe, !trw);
      chk("beat_val", AddrData_o, w);
      chk("beat_rw", rw, trw);
      chk("beat_rdy", req_ready, 0);
      chk("beat_rsp", rsp_valid, 0);
      req_valid = (k == pulse);
      if (k == rstb) begin
        resetH = 1'b1;
        #1;
        chk("rst_av", AddrValid, 0);
        chk("rst_oe", AddrData_oe, 0);
        chk("rst_val", AddrData_o, 0);
        chk("rst_rw", rw, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_rdy", req_ready, 1);
        chk("rst_rd", rsp_rdata, 0);
        step();
        resetH  = 1'b0;
        last_rd = '0;
        rd      = '0;
        return;
      end
    end
    step();
    req_valid = 1'b0;
    if (!trw) begin
      for (int k = 0; k < B; k++) begin
        ai = a + 16'(k);
        ref_mem[ai[7:0]] = wd[k*DW +: DW];
      end
    end else begin
      last_rd = xrd;
    end
    chk("done_rsp", rsp_valid, 1);
    chk("done_rdy", req_ready, 1);
    chk("done_av", AddrValid, 0);
    chk("done_oe", AddrData_oe, 0);
    chk("done_rd", rsp_rdata, last_rd);
    rd = rsp_rdata;
  endtask

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [63:0] wdata;
    int          gap;
    int          pulse;
    logic [63:0] xrd;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    logic        trw;
    logic [15:0] a;
    logic [63:0] wd;

    tbl[0] = '{1'b0, 16'h1000, 64'h4444_3333_2222_1111,
               2, -1, 64'h0};
    tbl[1] = '{1'b1, 16'h1000, 64'h0,
               1, -1, 64'h4444_3333_2222_1111};
    tbl[2] = '{1'b0, 16'h1008, 64'h8888_7777_6666_5555,
               1, -1, 64'h0};
    tbl[3] = '{1'b1, 16'h1008, 64'h0,
               0, -1, 64'h8888_7777_6666_5555};
    tbl[4] = '{1'b0, 16'h1004, 64'hDDDD_CCCC_BBBB_AAAA,
               1, 2, 64'h0};
    tbl[5] = '{1'b1, 16'h1002, 64'h0,
               3, -1, 64'hBBBB_AAAA_4444_3333};

    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    last_rd = '0;

    resetH      = 1'b0;
    req_valid   = 1'b0;
    req_rw      = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    req_valid1  = 1'b0;
    req_rw1     = 1'b0;
    req_addr1   = '0;
    req_wdata1  = '0;
    AddrData_i1 = '0;
    #1;
    resetH = 1'b1;
    #2;
    chk("r_rdy", req_ready, 1);
    chk("r_rsp", rsp_valid, 0);
    chk("r_av", AddrValid, 0);
    chk("r_rw", rw, 0);
    chk("r_val", AddrData_o, 0);
    chk("r_oe", AddrData_oe, 0);
    chk("r_rd", rsp_rdata, 0);
    chk("r1_rdy", req_ready1, 1);
    chk("r1_rd", rsp_rdata1, 0);
    step();
    step();
    resetH = 1'b0;
    idle(2);

    for (int i = 0; i < 6; i++) begin
      idle(tbl[i].gap);
      if (tbl[i].gap == 0) chk("b2b_rsp", rsp_valid, 1);
      txn(tbl[i].rw, tbl[i].addr, tbl[i].wdata,
          tbl[i].pulse, -1, rd);
      if (tbl[i].rw) chk("tbl_rd", rd, tbl[i].xrd);
    end

    idle(1);
    txn(1'b1, 16'h1000, 64'h0, -1, 2, rd);
    idle(3);
    txn(1'b0, 16'h100C, 64'hCAFE_F00D_1234_5678, -1, -1, rd);
    idle(1);
    txn(1'b1, 16'h100C, 64'h0, -1, -1, rd);
    chk("post_rst_rd", rd, 64'hCAFE_F00D_1234_5678);

    for (int i = 0; i < 40; i++) begin
      idle($urandom_range(0, 2));
      trw = 1'($urandom_range(0, 1));
      a   = 16'h1000 | 16'($urandom_range(0, 255));
      wd  = {$urandom, $urandom};
      txn(trw, a, wd, $urandom_range(0, 5), -1, rd);
    end
    idle(2);

    req_valid1 = 1'b1;
    req_rw1    = 1'b0;
    req_addr1  = 16'h1004;
    req_wdata1 = 16'hBEEF;
    step();
    req_valid1 = 1'b0;
    chk("b1_w_av", AddrValid1, 1);
    chk("b1_w_adr", AddrData_o1, 16'h1004);
    chk("b1_w_oe", AddrData_oe1, 1);
    step();
    chk("b1_w_dav", AddrValid1, 0);
    chk("b1_w_dat", AddrData_o1, 16'hBEEF);
    chk("b1_w_doe", AddrData_oe1, 1);
    chk("b1_w_rsp0", rsp_valid1, 0);
    step();
    chk("b1_w_rsp", rsp_valid1, 1);
    chk("b1_w_rdy", req_ready1, 1);
    req_valid1 = 1'b1;
    req_rw1    = 1'b1;
    step();
    req_valid1 = 1'b0;
    chk("b1_r_av", AddrValid1, 1);
    chk("b1_r_rw", rw1, 1);
    chk("b1_r_rsp0", rsp_valid1, 0);
    chk("b1_r_rd0", rsp_rdata1, 0);
    step();
    AddrData_i1 = 16'hBEEF;
    chk("b1_r_doe", AddrData_oe1, 0);
    chk("b1_r_dat", AddrData_o1, 0);
    step();
    AddrData_i1 = 16'h0;
    chk("b1_r_rsp", rsp_valid1, 1);
    chk("b1_r_rd", rsp_rdata1, 16'hBEEF);
    step();
    chk("b1_r_rsp1", rsp_valid1, 0);
    chk("b1_r_hold", rsp_rdata1, 16'hBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
